// File: rtl/l2_evict_buffer.sv
// Eviction write buffer between the L2 and pmem: absorbs dirty-line writebacks and drains them when the L2 is quiet.
// Optional hit/drain counters are compiled in with L2_EVICT_BUFFER_STATS_EN.
module l2_evict_buffer #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  mem_address,
  input  logic [127:0] mem_wdata,
  input  logic         mem_read,
  input  logic         mem_write,
  output logic [127:0] mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  output logic         pmem_read,
  output logic         pmem_write,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef L2_EVICT_BUFFER_STATS_EN
  ,
  output logic [15:0]  ewb_hits,
  output logic [15:0]  ewb_drains
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PREAD = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            valid_q [DEPTH];
  logic [11:0]     tag_q   [DEPTH];
  logic [127:0]    data_q  [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;

  logic            mem_resp_q, pmem_read_q, pmem_write_q;
  logic [15:0]     pmem_address_q;
  logic [127:0]    pmem_wdata_q, mem_rdata_q;

  logic            hit_s;
  logic [PW-1:0]   hit_idx_s;
  logic            push_s, coalesce_s, pop_s, load_hit_s, load_pmem_s;
  logic            unused_addr_bits_s;

  assign unused_addr_bits_s = ^mem_address[3:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Tag match across valid entries; coalescing keeps at most one hit.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = {PW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == mem_address[15:4])) begin
        hit_s     = 1'b1;
        hit_idx_s = PW'(i);
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // Next-state and buffer update strobes.
  always_comb begin
    state_d     = state_q;
    push_s      = 1'b0;
    coalesce_s  = 1'b0;
    pop_s       = 1'b0;
    load_hit_s  = 1'b0;
    load_pmem_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read) begin
          if (hit_s) begin
            load_hit_s = 1'b1;
            state_d    = RESP;
          end else begin
            state_d    = PREAD;
          end
        end else if (mem_write) begin
          if (hit_s) begin
            coalesce_s = 1'b1;
            state_d    = RESP;
          end else if (count_q < CW'(DEPTH)) begin
            push_s     = 1'b1;
            state_d    = RESP;
          end else begin
            // Full: free the head first; the write is taken on the return to IDLE.
            state_d    = DRAIN;
          end
        end else if (count_q != {CW{1'b0}}) begin
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      PREAD: begin
        if (pmem_resp) begin
          load_pmem_s = 1'b1;
          state_d     = RESP;
        end else begin
          state_d     = PREAD;
        end
      end
      DRAIN: begin
        if (pmem_resp) begin
          pop_s   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Entry storage and FIFO pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= 12'h000;
        data_q[i]  <= 128'h0;
      end
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        valid_q[tail_q] <= 1'b1;
        tag_q[tail_q]   <= mem_address[15:4];
        data_q[tail_q]  <= mem_wdata;
        tail_q          <= ptr_inc(tail_q);
        count_q         <= count_q + CW'(1);
      end else if (pop_s) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= ptr_inc(head_q);
        count_q         <= count_q - CW'(1);
      end else if (coalesce_s) begin
        data_q[hit_idx_s] <= mem_wdata;
      end
    end
  end

  // Registered outputs, loaded from the state being entered so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_resp_q     <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= 16'h0000;
      pmem_wdata_q   <= 128'h0;
      mem_rdata_q    <= 128'h0;
    end else begin
      mem_resp_q   <= (state_d == RESP);
      pmem_read_q  <= (state_d == PREAD);
      pmem_write_q <= (state_d == DRAIN);
      if (state_d == PREAD) begin
        pmem_address_q <= {mem_address[15:4], 4'h0};
      end else if (state_d == DRAIN) begin
        pmem_address_q <= {tag_q[head_q], 4'h0};
        pmem_wdata_q   <= data_q[head_q];
      end
      if (load_hit_s) begin
        mem_rdata_q <= data_q[hit_idx_s];
      end else if (load_pmem_s) begin
        mem_rdata_q <= pmem_rdata;
      end
    end
  end

  assign mem_resp     = mem_resp_q;
  assign mem_rdata    = mem_rdata_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

`ifdef L2_EVICT_BUFFER_STATS_EN
  logic [15:0] hits_q, drains_q;

  // Hit and drain counters, free-running with natural wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hits_q   <= 16'h0000;
      drains_q <= 16'h0000;
    end else begin
      if (load_hit_s || coalesce_s) begin
        hits_q <= hits_q + 16'h0001;
      end
      if (pop_s) begin
        drains_q <= drains_q + 16'h0001;
      end
    end
  end

  assign ewb_hits   = hits_q;
  assign ewb_drains = drains_q;
`endif

endmodule

// File: tb/tb_l2_evict_buffer.sv
// Bench for l2_evict_buffer: directed scenarios plus random traffic against a flat-memory reference view.
module tb_l2_evict_buffer;

  localparam int DEPTH = 2;

  logic         clk;
  logic         rst_n;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic         mem_read;
  logic         mem_write;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
`ifdef L2_EVICT_BUFFER_STATS_EN
  logic [15:0]  ewb_hits;
  logic [15:0]  ewb_drains;
`endif

  l2_evict_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
`ifdef L2_EVICT_BUFFER_STATS_EN
    ,
    .ewb_hits     (ewb_hits),
    .ewb_drains   (ewb_drains)
`endif
  );

  typedef struct packed {
    logic [11:0]  tag;
    logic [127:0] data;
  } ent_t;

  int checks = 0;
  int errors = 0;
  int pmem_lat = 2;
  int hits_exp = 0;
  int drains_exp = 0;

  ent_t         mq[$];
  logic [15:0]  drain_log[$];
  logic [127:0] ref_mem  [logic [11:0]];
  logic [127:0] pmem_mem [logic [11:0]];
  logic [15:0]  last_read_addr = 16'h0000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] init_line(input logic [11:0] t);
    return {8{t, 4'h5}};
  endfunction

  function automatic logic [127:0] pmem_lookup(input logic [11:0] t);
    if (pmem_mem.exists(t)) return pmem_mem[t];
    return init_line(t);
  endfunction

  function automatic logic [127:0] ref_read(input logic [11:0] t);
    if (ref_mem.exists(t)) return ref_mem[t];
    return init_line(t);
  endfunction

  function automatic int mq_find(input logic [11:0] t);
    foreach (mq[i]) if (mq[i].tag == t) return i;
    return -1;
  endfunction

  // A pmem write completing must retire the oldest buffered line.
  task automatic complete_drain(input logic [15:0] addr, input logic [127:0] data);
    if (mq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL drain_unexpected observed=%h expected=no_write", addr);
    end else begin
      check("drain_addr", addr, {mq[0].tag, 4'h0});
      check("drain_data", data, mq[0].data);
      pmem_mem[mq[0].tag] = mq[0].data;
      void'(mq.pop_front());
    end
    drains_exp++;
    drain_log.push_back(addr);
  endtask

  // pmem responder with programmable latency; also checks request stability.
  initial begin : pmem_model
    int busy;
    logic [15:0]  cap_addr;
    logic [127:0] cap_wdata;
    logic         cap_wr;
    busy = 0;
    cap_addr = 16'h0000;
    cap_wdata = 128'h0;
    cap_wr = 1'b0;
    pmem_resp = 1'b0;
    pmem_rdata = 128'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pmem_resp = 1'b0;
        busy = 0;
      end else if (pmem_resp) begin
        pmem_resp = 1'b0;
        busy = 0;
      end else if (pmem_read || pmem_write) begin
        check("pmem_rw_exclusive", pmem_read & pmem_write, 1'b0);
        if (busy == 0) begin
          cap_addr = pmem_address;
          cap_wdata = pmem_wdata;
          cap_wr = pmem_write;
          check("pmem_addr_align", pmem_address[3:0], 4'h0);
          if (pmem_read) last_read_addr = pmem_address;
        end else begin
          check("pmem_addr_stable", pmem_address, cap_addr);
          if (cap_wr) check("pmem_wdata_stable", pmem_wdata, cap_wdata);
        end
        busy++;
        if (busy >= pmem_lat) begin
          pmem_resp = 1'b1;
          if (pmem_write) complete_drain(pmem_address, pmem_wdata);
          else pmem_rdata = pmem_lookup(pmem_address[15:4]);
        end
      end else begin
        busy = 0;
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Latency is the clock edge (counted from the request) at which the L2 samples mem_resp.
  task automatic req(input bit wr, input logic [15:0] addr, input logic [127:0] wd,
                     output int lat, output bit saw, output logic [127:0] rd);
    int cyc;
    bit got;
    mem_address = addr;
    mem_wdata = wd;
    mem_read = !wr;
    mem_write = wr;
    cyc = 0;
    saw = 1'b0;
    got = 1'b0;
    while (!got && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
      if (pmem_read) saw = 1'b1;
      if (mem_resp) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL req_timeout observed=no_resp expected=mem_resp addr=%h", addr);
    end
    lat = cyc + 1;
    rd = mem_rdata;
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    check("resp_one_cycle", mem_resp, 1'b0);
  endtask

  task automatic l2_op(input bit wr, input logic [15:0] addr, input logic [127:0] wd,
                       output int lat, output bit saw);
    logic [11:0]  t;
    logic [127:0] rd;
    int idx;
    t = addr[15:4];
    req(wr, addr, wd, lat, saw, rd);
    idx = mq_find(t);
    if (!wr) begin
      check("rd_data", rd, ref_read(t));
      check("rd_pmem_iff_miss", saw, (idx < 0));
      if (idx >= 0) hits_exp++;
    end else begin
      check("wr_no_pread", saw, 1'b0);
      if (idx >= 0) begin
        mq[idx].data = wd;
        hits_exp++;
      end else begin
        mq.push_back('{tag: t, data: wd});
        check("occupancy", (mq.size() <= DEPTH), 1'b1);
      end
      ref_mem[t] = wd;
    end
  endtask

  task automatic wait_empty();
    int c;
    c = 0;
    while (mq.size() != 0 && c < 3000) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (mq.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout observed=%0d expected=0", mq.size());
    end
    idle_cycles(4);
  endtask

  initial begin : main
    int lat;
    bit saw;
    int d0;
    int c;
    logic [15:0] exp_log [3];
    logic [15:0] a;
    logic [127:0] d;
    bit wr;

    rst_n = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_address = 16'h0000;
    mem_wdata = 128'h0;
    idle_cycles(3);
    check("rst_mem_resp", mem_resp, 1'b0);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_mem_rdata", mem_rdata, 128'h0);
    check("rst_pmem_address", pmem_address, 16'h0000);
    check("rst_pmem_wdata", pmem_wdata, 128'h0);
    rst_n = 1'b1;

    // Write then read hit, back to back.
    pmem_lat = 2;
    l2_op(1'b1, 16'h1234, 128'hD1D1_0000_1111_2222_3333_4444_5555_6666, lat, saw);
    check("hit_wr_latency", lat, 2);
    l2_op(1'b0, 16'h123C, 128'h0, lat, saw);
    check("hit_rd_latency", lat, 2);
    wait_empty();

    // Coalesce: two writes to one line give a single drain with the newer data.
    d0 = drains_exp;
    l2_op(1'b1, 16'h4000, 128'hD1D1_D1D1_D1D1_D1D1_D1D1_D1D1_D1D1_D1D1, lat, saw);
    l2_op(1'b1, 16'h4008, 128'hD2D2_D2D2_D2D2_D2D2_D2D2_D2D2_D2D2_D2D2, lat, saw);
    check("coalesce_latency", lat, 2);
    wait_empty();
    idle_cycles(10);
    check("coalesce_one_drain", drains_exp - d0, 1);

    // Full stall: third distinct line waits for the head drain.
    pmem_lat = 3;
    drain_log.delete();
    l2_op(1'b1, 16'h1000, 128'hA0, lat, saw);
    check("full_wr0_latency", lat, 2);
    l2_op(1'b1, 16'h2000, 128'hA1, lat, saw);
    check("full_wr1_latency", lat, 2);
    l2_op(1'b1, 16'h3000, 128'hA2, lat, saw);
    check("full_stall_latency", lat, 3 + 3);
    wait_empty();
    exp_log[0] = 16'h1000;
    exp_log[1] = 16'h2000;
    exp_log[2] = 16'h3000;
    check("full_drain_count", drain_log.size(), 3);
    for (int i = 0; i < 3 && i < drain_log.size(); i++) check("full_drain_order", drain_log[i], exp_log[i]);

    // Read miss passthrough with a 5-cycle pmem.
    pmem_lat = 5;
    pmem_mem[12'h5A5] = 128'hD3D3_D3D3_0123_4567_89AB_CDEF_D3D3_D3D3;
    ref_mem[12'h5A5]  = 128'hD3D3_D3D3_0123_4567_89AB_CDEF_D3D3_D3D3;
    l2_op(1'b0, 16'h5A5F, 128'h0, lat, saw);
    check("miss_pmem_addr", last_read_addr, 16'h5A50);
    check("miss_latency", lat, 5 + 2);

    // Idle drain starts on the first quiet IDLE cycle.
    pmem_lat = 4;
    d0 = drains_exp;
    l2_op(1'b1, 16'h7770, 128'h7777_0000_7777_0000_7777_0000_7777_0000, lat, saw);
    idle_cycles(1);
    check("idle_drain_start", pmem_write, 1'b1);
    check("idle_drain_addr", pmem_address, 16'h7770);
    wait_empty();
    check("idle_drain_count", drains_exp - d0, 1);

    // Reset while a drain is outstanding discards the buffered line.
    pmem_lat = 50;
    l2_op(1'b1, 16'h6660, 128'hD4D4_D4D4_D4D4_D4D4_D4D4_D4D4_D4D4_D4D4, lat, saw);
    c = 0;
    while (!pmem_write && c < 20) begin
      idle_cycles(1);
      c++;
    end
    check("rst_drain_started", pmem_write, 1'b1);
    rst_n = 1'b0;
    idle_cycles(1);
    check("midrst_pmem_write", pmem_write, 1'b0);
    check("midrst_pmem_read", pmem_read, 1'b0);
    check("midrst_mem_resp", mem_resp, 1'b0);
    rst_n = 1'b1;
    mq.delete();
    ref_mem[12'h666] = pmem_lookup(12'h666);
    hits_exp = 0;
    drains_exp = 0;
    pmem_lat = 2;
    l2_op(1'b0, 16'h6660, 128'h0, lat, saw);
    check("post_rst_miss", saw, 1'b1);
    check("post_rst_latency", lat, 2 + 2);

    // Random traffic over a small set of lines.
    for (int n = 0; n < 300; n++) begin
      pmem_lat = $urandom_range(1, 4);
      wr = 1'($urandom_range(0, 1));
      a = 16'h1000 | (16'($urandom_range(0, 7)) << 4) | 16'($urandom_range(0, 15));
      d = {$urandom, $urandom, $urandom, $urandom};
      l2_op(wr, a, d, lat, saw);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 6));
    end
    wait_empty();
    idle_cycles(10);
    foreach (ref_mem[k]) check("final_pmem_image", pmem_lookup(k), ref_mem[k]);

`ifdef L2_EVICT_BUFFER_STATS_EN
    check("stats_hits", ewb_hits, 16'(hits_exp));
    check("stats_drains", ewb_drains, 16'(drains_exp));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_evict_buffer.md
Name: l2_evict_buffer

Overview:
Eviction write buffer between l2_cache and physical memory. It absorbs dirty-line writebacks from the L2, so an L2 miss-with-eviction does not pay two serial pmem latencies. It drains buffered lines to pmem when the L2 is quiet. It serves L2 reads from the buffer on a line-address match and otherwise forwards them to pmem.

Parameters:
DEPTH, 2, number of line entries; power of 2, minimum 1.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
mem_address  in  16 (lc3b_word)  L2-side byte address; bits [3:0] ignored
mem_wdata  in  128 (lc3b_cache_line)  L2 writeback line
mem_read  in  1  L2 line read request
mem_write  in  1  L2 line write (eviction) request
mem_rdata  out  128  line returned to L2
mem_resp  out  1  one-cycle completion pulse to L2
pmem_address  out  16  pmem line address, bits [3:0] = 0
pmem_wdata  out  128  line to pmem
pmem_read  out  1  pmem read request
pmem_write  out  1  pmem write request
pmem_rdata  in  128  line from pmem
pmem_resp  in  1  pmem completion

Behaviour:
- Entry state: valid, line tag {address[15:4]}, and 128-bit data. Entries form a circular FIFO with head/tail pointers and a count of 0..DEPTH.
- Reset (rst_n=0 at a clk edge):
  - count=0, all valid=0, FSM=IDLE.
  - mem_resp, pmem_read and pmem_write = 0.
  - mem_rdata=0, pmem_address=0, pmem_wdata=0.
  - Reset mid-drain or mid-read abandons the pmem transaction: requests drop the next cycle and buffered data is discarded.
- FSM states: IDLE, PREAD, DRAIN, RESP.
- IDLE, priority order:
  1. mem_read and tag match: latch matching entry data into mem_rdata, go to RESP.
  2. mem_read and no match: go to PREAD.
  3. mem_write and tag match: overwrite that entry's data in place (coalesce, count unchanged), go to RESP.
  4. mem_write, no match, count<DEPTH: write at tail, count+1, go to RESP.
  5. mem_write, no match, count==DEPTH: go to DRAIN. The write is accepted after the pop.
  6. No request and count>0: go to DRAIN.
  7. Otherwise stay in IDLE.
- PREAD:
  - Drive pmem_read=1 and pmem_address={mem_address[15:4],4'b0}.
  - On pmem_resp, latch pmem_rdata into mem_rdata and go to RESP.
- DRAIN:
  - Drive pmem_write=1, pmem_address={head tag,4'b0}, pmem_wdata=head data. These are held stable until pmem_resp.
  - On pmem_resp: invalidate head, advance head (wraps modulo DEPTH), count-1, go to IDLE.
  - Upstream requests arriving during DRAIN wait; no overlap with pmem.
- RESP: mem_resp=1 for exactly one cycle, then IDLE. The L2 drops its request on the edge where it sees mem_resp.
- Latency:
  - Buffer hit and non-full write: mem_resp 2 cycles after request assertion.
  - Read miss: pmem latency + 2.
  - Write when full: drain latency + 3.
- At most one valid entry per line tag, guaranteed by coalescing. Match logic ORs across valid entries only.
- pmem_read and pmem_write are never asserted together.
- mem_read and mem_write asserted together is illegal. Read takes priority.

Optional Feature:
Macro: L2_EVICT_BUFFER_STATS_EN.
- Defined: adds output ports ewb_hits (16) and ewb_drains (16).
  - ewb_hits increments on each IDLE read-match or write-coalesce.
  - ewb_drains increments on each DRAIN pmem_resp.
  - Both wrap at 16'hFFFF→0 and reset to 0 on rst_n=0.
- Undefined: ports and counters are absent. Functional behaviour is identical.

Test Plan:
- Write then read hit: mem_write 0x1234 data D1; then mem_read 0x123C → mem_resp 2 cycles after each request, mem_rdata=D1, no pmem_read asserted.
- Coalesce: write 0x4000 D1, then 0x4008 D2 before any drain (bench holds pmem idle by back-to-back requests) → count stays 1; later drain writes pmem_address 0x4000 with D2 only.
- Full stall (DEPTH=2): write lines 0x1000, 0x2000, then 0x3000 → pmem_write to 0x1000 first; after pmem_resp, 0x3000 accepted; total drains in order 0x1000, 0x2000, 0x3000.
- Read miss passthrough: empty buffer, mem_read 0x5A5F → pmem_read with pmem_address 0x5A50; pmem_resp with D3 after 5 cycles → mem_resp on cycle 7, mem_rdata=D3.
- Idle drain: one write to 0x7770 then no requests → DRAIN entered next IDLE cycle; pmem_wdata stable until pmem_resp; count returns to 0; stats build ewb_drains=1.
- Reset mid-drain: assert rst_n=0 while pmem_write=1 → next cycle pmem_write=0, mem_resp=0, count=0; subsequent mem_read of drained address misses to pmem.
